// File: rtl/hsv_commit_pkg.sv
// Shared types for the commit/writeback path: machine word and the per-unit
// commit payload carried from the execution units to the arbiter.
package hsv_commit_pkg;

    typedef logic [31:0] word;

    typedef struct packed {
        word        result;
        logic [4:0] rd;
        logic       writeback;
    } commit_data_t;

endpackage

// File: rtl/hsv_core_commit_arbiter_if.sv
// Commit stream bundle: NUM_UNITS execution-unit inputs merged into one output.
// slave = arbiter side, master = producer/consumer side.
interface hsv_core_commit_arbiter_if #(
    parameter int NUM_UNITS = 2
);
    import hsv_commit_pkg::*;

    commit_data_t [NUM_UNITS-1:0] in_commit;
    logic         [NUM_UNITS-1:0] in_valid;
    logic         [NUM_UNITS-1:0] in_ready;
    commit_data_t                 out_commit;
    logic                         out_valid;
    logic                         out_ready;

    modport slave (
        input  in_commit,
        input  in_valid,
        output in_ready,
        output out_commit,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_commit,
        output in_valid,
        input  in_ready,
        input  out_commit,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// Round-robin commit arbiter with a single output stage, writeback port and flush.
// Optional performance counters are enabled by defining HSV_COMMIT_PERF_EN.
module hsv_core_commit_arbiter
    import hsv_commit_pkg::*;
#(
    parameter int NUM_UNITS  = 2,
    parameter int PERF_WIDTH = 32
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    flush_req,
    output logic                    flush_ack,
    hsv_core_commit_arbiter_if.slave bus,
    output logic                    wb_en,
    output logic [4:0]              wb_rd,
    output word                     wb_value
`ifdef HSV_COMMIT_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]   perf_commits,
    output logic [PERF_WIDTH-1:0]   perf_stalls
`endif
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    if ((NUM_UNITS < 2) || (NUM_UNITS > 8) || (PERF_WIDTH < 1)) begin : g_bad_cfg
        $error("hsv_core_commit_arbiter: NUM_UNITS must be 2..8 and PERF_WIDTH >= 1");
    end

    logic [0:0]           r_state;
    logic [PTR_W-1:0]     r_ptr;
    commit_data_t         r_out_commit;
    logic                 r_out_valid;
    logic                 r_flush_ack;

    logic [NUM_UNITS-1:0] w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic                 w_found;
    logic                 w_can_load;
    logic                 w_accept;

    // Round-robin search starting one past the last accepted unit.
    always_comb begin
        int idx;
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        idx         = 0;
        for (int i = 1; i <= NUM_UNITS; i++) begin
            idx = (int'(r_ptr) + i) % NUM_UNITS;
            if (!w_found && bus.in_valid[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_grant_idx  = PTR_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Stage may load when empty or draining, never while flushing.
    always_comb begin
        w_can_load  = (~r_out_valid | bus.out_ready) & (r_state == ST_RUN) & ~flush_req;
        bus.in_ready = w_grant & {NUM_UNITS{w_can_load}};
        w_accept    = w_found & w_can_load;
    end

    // Output stage, arbitration pointer, flush state and acknowledge.
    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            r_state      <= ST_RUN;
            r_ptr        <= PTR_W'(NUM_UNITS - 1);
            r_out_commit <= '0;
            r_out_valid  <= 1'b0;
            r_flush_ack  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= flush_req ? ST_FLUSH : ST_RUN;
                ST_FLUSH: r_state <= flush_req ? ST_FLUSH : ST_RUN;
                default:  r_state <= ST_RUN;
            endcase

            if (flush_req) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_commit <= bus.in_commit[w_grant_idx];
                r_out_valid  <= 1'b1;
                r_ptr        <= w_grant_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // The stage is always empty after an edge that saw flush_req.
            r_flush_ack <= flush_req;
        end
    end

    // Writeback is a pure function of the output stage and the downstream handshake.
    always_comb begin
        bus.out_commit = r_out_commit;
        bus.out_valid  = r_out_valid;
        flush_ack      = r_flush_ack;
        wb_rd          = r_out_commit.rd;
        wb_value       = r_out_commit.result;
        wb_en          = r_out_valid & bus.out_ready & r_out_commit.writeback &
                         (r_out_commit.rd != 5'd0) & ~flush_req;
    end

`ifdef HSV_COMMIT_PERF_EN
    logic [PERF_WIDTH-1:0] r_perf_commits;
    logic [PERF_WIDTH-1:0] r_perf_stalls;

    // Free-running wrap-around counters; flush does not clear them.
    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            r_perf_commits <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_perf_commits <= r_perf_commits + PERF_WIDTH'(1);
            end
            if (r_out_valid && !bus.out_ready) begin
                r_perf_stalls <= r_perf_stalls + PERF_WIDTH'(1);
            end
        end
    end

    assign perf_commits = r_perf_commits;
    assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// Bench for hsv_core_commit_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hsv_core_commit_arbiter;
    import hsv_commit_pkg::*;

    localparam int N  = 2;
    localparam int PW = 32;

    logic       clk_core;
    logic       rst_core;
    logic       flush_req;
    logic       flush_ack;
    logic       wb_en;
    logic [4:0] wb_rd;
    word        wb_value;
`ifdef HSV_COMMIT_PERF_EN
    logic [PW-1:0] perf_commits;
    logic [PW-1:0] perf_stalls;
`endif

    hsv_core_commit_arbiter_if #(.NUM_UNITS(N)) bus ();

    hsv_core_commit_arbiter #(.NUM_UNITS(N), .PERF_WIDTH(PW)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .bus       (bus),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_value  (wb_value)
`ifdef HSV_COMMIT_PERF_EN
        ,
        .perf_commits (perf_commits),
        .perf_stalls  (perf_stalls)
`endif
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    commit_data_t m_held[$];
    int           m_last     = N - 1;
    bit           m_flushing = 1'b0;
    bit           m_ack      = 1'b0;
    logic [PW-1:0] m_commits = '0;
    logic [PW-1:0] m_stalls  = '0;

    function automatic int next_winner(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    initial begin
        @(posedge clk_core);
        forever begin
            int            w;
            bit            can_load;
            logic [N-1:0]  exp_ready;
            bit            exp_wb;
            @(negedge clk_core);
            w         = next_winner(bus.in_valid, m_last);
            can_load  = ((m_held.size() == 0) || bus.out_ready) && !m_flushing && !flush_req;
            exp_ready = '0;
            if (can_load && w >= 0) exp_ready[w] = 1'b1;
            exp_wb = (m_held.size() != 0) && bus.out_ready && !flush_req &&
                     m_held[0].writeback && (m_held[0].rd != 5'd0);

            chk("out_valid", 64'(bus.out_valid), 64'(m_held.size() != 0));
            chk("in_ready",  64'(bus.in_ready),  64'(exp_ready));
            chk("flush_ack", 64'(flush_ack),     64'(m_ack));
            chk("wb_en",     64'(wb_en),         64'(exp_wb));
            if (m_held.size() != 0) begin
                chk("out_commit", 64'(bus.out_commit), 64'(m_held[0]));
                chk("wb_rd",      64'(wb_rd),          64'(m_held[0].rd));
                chk("wb_value",   64'(wb_value),       64'(m_held[0].result));
            end
`ifdef HSV_COMMIT_PERF_EN
            chk("perf_commits", 64'(perf_commits), 64'(m_commits));
            chk("perf_stalls",  64'(perf_stalls),  64'(m_stalls));
`endif
            // advance the model to the state after the coming edge
            if (!rst_core) begin
                m_held.delete();
                m_last     = N - 1;
                m_flushing = 1'b0;
                m_ack      = 1'b0;
                m_commits  = '0;
                m_stalls   = '0;
            end else begin
                if (m_held.size() != 0 && bus.out_ready)  m_commits = m_commits + 1'b1;
                if (m_held.size() != 0 && !bus.out_ready) m_stalls  = m_stalls + 1'b1;
                if (flush_req) begin
                    m_held.delete();
                end else if (can_load && w >= 0) begin
                    m_held.delete();
                    m_held.push_back(bus.in_commit[w]);
                    m_last = w;
                end else if (bus.out_ready) begin
                    m_held.delete();
                end
                m_flushing = flush_req;
                m_ack      = flush_req;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        flush_req     = 1'b0;
    endtask

    function automatic commit_data_t mk(input logic [4:0] rd, input word res, input logic wbk);
        commit_data_t c;
        c.rd = rd; c.result = res; c.writeback = wbk;
        return c;
    endfunction

    task automatic do_reset();
        rst_core = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_core = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int g0;
        int g1;
        int wb_hits;
        logic [N-1:0] exp_seq;
        commit_data_t held;

        rst_core      = 1'b0;
        flush_req     = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        bus.in_commit = '0;
        do_reset();

        @(negedge clk_core);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_flush_ack", 64'(flush_ack),     64'd0);

        // single result
        tick();
        bus.in_commit[0] = mk(5'd5, 32'h0000_002A, 1'b1);
        bus.in_valid     = 2'b01;
        @(negedge clk_core);
        chk("single_in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = '0;
        wb_hits = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            if (wb_en && wb_rd == 5'd5 && wb_value == 32'h2A) wb_hits++;
            tick();
        end
        chk("single_wb_once", 64'(wb_hits), 64'd1);

        // fairness after reset
        do_reset();
        tick();
        bus.in_commit[0] = mk(5'd1, 32'h1111_0000, 1'b1);
        bus.in_commit[1] = mk(5'd2, 32'h2222_0000, 1'b1);
        bus.in_valid     = 2'b11;
        g0 = 0; g1 = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_commit[0].result[7:0] = 8'(c);
            bus.in_commit[1].result[7:0] = 8'(c);
            @(negedge clk_core);
            exp_seq = ((c % 2) == 0) ? 2'b01 : 2'b10;
            chk("fair_grant", 64'(bus.in_ready), 64'(exp_seq));
            if (bus.in_ready == 2'b01) g0++;
            if (bus.in_ready == 2'b10) g1++;
            tick();
        end
        chk("fair_count0", 64'(g0), 64'd4);
        chk("fair_count1", 64'(g1), 64'd4);
        idle_inputs();
        tick();

        // back-pressure with perf counters cleared by reset
        do_reset();
        tick();
        bus.in_commit[1] = mk(5'd7, 32'hCAFE_0001, 1'b1);
        bus.in_valid     = 2'b10;
        tick();
        held             = mk(5'd7, 32'hCAFE_0001, 1'b1);
        bus.in_commit[1] = mk(5'd8, 32'hBEEF_0002, 1'b1);
        bus.out_ready    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core);
            chk("bp_stable",   64'(bus.out_commit), 64'(held));
            chk("bp_in_ready", 64'(bus.in_ready),   64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = '0;
        @(negedge clk_core);
        chk("bp_release_wb", 64'({wb_en, wb_rd}), 64'({1'b1, 5'd7}));
        tick();
`ifdef HSV_COMMIT_PERF_EN
        @(negedge clk_core);
        chk("bp_perf_stalls",  64'(perf_stalls),  64'd3);
        chk("bp_perf_commits", 64'(perf_commits), 64'd1);
`endif

        // x0 suppression
        bus.in_commit[0] = mk(5'd0, 32'h0000_0099, 1'b1);
        bus.in_valid     = 2'b01;
        tick();
        bus.in_valid = '0;
        @(negedge clk_core);
        chk("x0_out_valid", 64'(bus.out_valid), 64'd1);
        chk("x0_wb_en",     64'(wb_en),         64'd0);
        tick();

        // flush with a pending handshake and both units valid
        bus.in_commit[0] = mk(5'd3, 32'h0000_0333, 1'b1);
        bus.in_commit[1] = mk(5'd4, 32'h0000_0444, 1'b1);
        bus.in_valid     = 2'b11;
        bus.out_ready    = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        flush_req     = 1'b1;
        @(negedge clk_core);
        chk("fl0_valid", 64'(bus.out_valid), 64'd1);
        chk("fl0_wb",    64'(wb_en),         64'd0);
        chk("fl0_ready", 64'(bus.in_ready),  64'd0);
        chk("fl0_ack",   64'(flush_ack),     64'd0);
        tick();
        @(negedge clk_core);
        chk("fl1_valid", 64'(bus.out_valid), 64'd0);
        chk("fl1_ready", 64'(bus.in_ready),  64'd0);
        chk("fl1_ack",   64'(flush_ack),     64'd1);
        tick();
        flush_req = 1'b0;
        @(negedge clk_core);
        chk("fl2_ready", 64'(bus.in_ready), 64'd0);
        chk("fl2_ack",   64'(flush_ack),    64'd1);
        tick();
        @(negedge clk_core);
        chk("fl3_ack",    64'(flush_ack),       64'd0);
        chk("fl3_resume", 64'(|bus.in_ready),   64'd1);
        tick();

        // reset mid-stall
        bus.out_ready = 1'b0;
        tick();
        @(negedge clk_core);
        chk("rs_pre_valid", 64'(bus.out_valid), 64'd1);
        tick();
        rst_core = 1'b0;
        tick();
        rst_core      = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk_core);
        chk("rs_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_ack",   64'(flush_ack),     64'd0);
        chk("rs_wb",    64'(wb_en),         64'd0);
        chk("rs_grant", 64'(bus.in_ready),  64'h1);
        tick();
        idle_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv_core_commit_arbiter.md
# hsv_core_commit_arbiter

Merges the `commit_data_t` result streams of the execution units into the single commit/writeback path. The ALU is unit 0 and feeds from its `alu_2_commit` skid buffer. Other execution units occupy the remaining ports. The block round-robins among valid units, registers the winner into one output stage, drives the register-file write port on output handshake, and participates in pipeline flush.

## Interface
Parameters:
- `NUM_UNITS`, default 2: number of execution-unit input channels, range 2..8; index 0 = ALU.
- `PERF_WIDTH`, default 32: width of performance counters; used only with the perf macro.

Ports:
- `clk_core`, in, 1: core clock; all state on rising edge.
- `rst_core`, in, 1: reset, synchronous, active-low.
- `flush_req`, in, 1: pipeline flush request.
- `flush_ack`, out, 1: flush acknowledged, registered.
- `in_commit`, in, `NUM_UNITS` x `commit_data_t`: per-unit commit payloads.
- `in_valid`, in, `NUM_UNITS`: per-unit valid.
- `in_ready`, out, `NUM_UNITS`: per-unit ready, one-hot or zero.
- `out_commit`, out, `commit_data_t`: registered selected payload.
- `out_valid`, out, 1: `out_commit` holds a result.
- `out_ready`, in, 1: downstream commit logic accepts.
- `wb_en`, out, 1: register-file write enable.
- `wb_rd`, out, 5: destination register, equal to `out_commit.rd`.
- `wb_value`, out, `word`: write data, equal to `out_commit.result`.
- `perf_commits`, out, `PERF_WIDTH`: present only with `HSV_COMMIT_PERF_EN`.
- `perf_stalls`, out, `PERF_WIDTH`: present only with `HSV_COMMIT_PERF_EN`.

## Operation
- State machine with two states, RUN and FLUSH; reset state is RUN.
- **RUN to FLUSH:** when `flush_req` = 1.
- **FLUSH to RUN:** when `flush_req` = 0.
- **Arbitration pointer:** `ptr` has reset value `NUM_UNITS-1`.
  - The grant goes to the first `k` with `in_valid[k]` = 1, searching `ptr+1, ptr+2, …` modulo `NUM_UNITS`.
  - On an accepted input from unit `k`, `ptr` <= `k`. Otherwise `ptr` holds.
- **Readiness:** `can_load` = (~`out_valid` | `out_ready`) & state==RUN & ~`flush_req`.
- **Input ready:** `in_ready[k]` = `grant[k]` & `can_load`. It must not depend combinationally on `in_valid[k]` of the same unit beyond grant selection.
- **Output register update (input accepted):** `out_commit` <= `in_commit[k]` and `out_valid` <= 1.
- **Output register update (no input, `out_ready` = 1):** `out_valid` <= 0.
- **Output register update otherwise:** `out_commit` and `out_valid` hold, and payload must stay stable while `out_valid` & ~`out_ready`.
- **Writeback:** `wb_en` = `out_valid` & `out_ready` & `out_commit.writeback` & (`out_commit.rd` != 0) & ~`flush_req`. Writes to x0 are never issued.
- **Flush:** when `flush_req` = 1, `out_valid` <= 0 at the next edge and all `in_ready` = 0 combinationally.
- **Flush acknowledge:** `flush_ack` <= (`flush_req` & stage empty after this edge). It is therefore 1 from the cycle after `flush_req` is first sampled until the cycle after `flush_req` drops.
- **Reset values:** `out_valid`=0, `flush_ack`=0, `ptr`=`NUM_UNITS-1`, state RUN, perf counters 0. `out_commit` reset value is don't-care. `wb_en` is 0 since `out_valid`=0.

## Timing
- **Latency:** 1 cycle from input handshake to `out_valid`.
- **Throughput:** 1 result/cycle with `out_ready` held high.
- **Back-pressure:** `out_valid`=1 & `out_ready`=0 forces all `in_ready`=0 in that cycle. There is no internal buffering beyond the single stage.
- **Simultaneous events:**
  - Output handshake plus new accept in the same cycle gives back-to-back output, no bubble.
  - `flush_req` in the same cycle as a pending handshake takes priority: no accept, no `wb_en`, and `out_valid` cleared.
- **Reset mid-operation:** the held result is dropped, no `wb_en` fires during or after reset, and arbitration restarts at unit 0.
- `wb_en`, `wb_rd` and `wb_value` are combinational from the output register and `out_ready`. There is no path from `in_*` to `wb_*`.

## Configuration
- **Macro:** `HSV_COMMIT_PERF_EN`.
- **Defined:** the `perf_commits` and `perf_stalls` ports exist.
  - `perf_commits` +1 on every output handshake.
  - `perf_stalls` +1 on every cycle with `out_valid` & ~`out_ready`.
  - Both wrap modulo 2^`PERF_WIDTH`, are zeroed by reset, and are not cleared by flush.
- **Undefined:** the ports and counters are absent. Arbitration, flush and writeback behaviour are identical in both builds.

## Test plan
- **Single result:** unit 0 presents rd=5, result=0x0000_002A, writeback=1 for one cycle; `out_ready`=1. Expect `in_ready[0]`=1, `out_valid` the next cycle, and `wb_en`=1 with `wb_rd`=5, `wb_value`=0x2A exactly once.
- **Fairness:** both units valid continuously; `out_ready`=1. Grants alternate 0,1,0,1 starting with unit 0 after reset; each unit receives 4 of 8 accepts.
- **Back-pressure:** unit 1 valid; `out_ready`=0 for 3 cycles, then 1. Expect `out_commit` stable for 3 cycles, all `in_ready`=0, and one handshake on release; `perf_stalls`=3 when the macro is defined.
- **x0 suppression:** rd=0, writeback=1. Expect an output handshake with `wb_en`=0.
- **Flush:** `flush_req`=1 for 2 cycles while `out_valid`=1 and both units are valid.
  - Expect `out_valid`=0 on the next edge, no `wb_en`, and `in_ready`=0 throughout.
  - Expect `flush_ack`=1 for 2 cycles starting 1 cycle after `flush_req` rises.
  - Accepts resume the cycle after `flush_req` falls.
- **Reset mid-stall:** with `out_valid`=1 and `out_ready`=0, pulse `rst_core`=0 for one cycle. Expect `out_valid`=0, `flush_ack`=0, no `wb_en`, and the first subsequent grant to unit 0.
